// File: rtl/fetch_responder.sv
// fetch_responder: boot-region instruction fetch responder with wait states and address-error responses.
// Ports: clk, reset (async, active-high); req_valid/req_addr/req_ready request handshake;
// rsp_valid/rsp_ready/rsp_data/rsp_err response handshake; mem_en/mem_addr/mem_rdata boot memory.
// Macro FETCH_RESP_ALIGN_CHECK_EN: when defined, misaligned addresses produce error responses.
module fetch_responder #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 2,
  parameter logic [WIDTH-1:0] BOOT_BASE = 32'hBFC00000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [WIDTH-1:0]  req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata
);
`ifdef FETCH_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic in_range, addr_err;
  assign in_range = req_addr[WIDTH-1:ADDR_W+2] == BOOT_BASE[WIDTH-1:ADDR_W+2];
  assign addr_err = !in_range || (ALIGN_CHECK && |req_addr[1:0]);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          if (addr_err) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end else begin
            state    <= ACCESS;
            mem_en   <= 1'b1;
            mem_addr <= req_addr[ADDR_W+1:2];
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= mem_rdata;
          end else begin
            state <= WAIT;
            cnt   <= 4'(WAIT_CYCLES - 1);
          end
        end
        WAIT: if (cnt == 4'd0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= mem_rdata;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: scoreboard bench for fetch_responder with directed fetch vectors.
module tb_fetch_responder;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic req_ready, rsp_valid, rsp_err, mem_en;
  logic [31:0] rsp_data, mem_rdata;
  logic [9:0] mem_addr, last_maddr;
  logic [31:0] rom [0:1023];
  int checks = 0, failures = 0, cyc = 0, mem_cnt = 0;
  typedef struct {logic [31:0] d; logic e; int c;} exp_t;
  exp_t q[$];
  exp_t x;
  logic prev = 1'b0, he;
  logic [31:0] hd;

  fetch_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = rom[mem_addr];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (mem_en === 1'b1) begin
    mem_cnt++;
    last_maddr = mem_addr;
  end

  always @(negedge clk) begin
    if (rsp_valid && !prev) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        x = q.pop_front();
        chk("rsp_data", rsp_data, x.d);
        chk("rsp_err", rsp_err, x.e);
        chk("rsp_cycle", cyc, x.c);
      end
      hd = rsp_data;
      he = rsp_err;
    end else if (rsp_valid && prev) begin
      chk("hold_data", rsp_data, hd);
      chk("hold_err", rsp_err, he);
      chk("resp_req_ready_low", req_ready, 0);
    end
    prev = rsp_valid;
  end

  task automatic do_req(logic [31:0] a, logic [31:0] d, logic e, logic [9:0] ma, int stall);
    int m0, n;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    m0 = mem_cnt;
    q.push_back('{d, e, cyc + 1 + (e ? 0 : 3)});
    req_valid = 1'b1;
    req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom();
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_req_ready", req_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("mem_en_count", mem_cnt - m0, e ? 0 : 1);
    if (!e) chk("mem_addr", last_maddr, ma);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA5C30000 + i;
    rom[0] = 32'h3C1D8000;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    do_req(32'hBFC00000, 32'h3C1D8000, 1'b0, 10'h000, 0);
    do_req(32'h00400000, 32'h00000000, 1'b1, 10'h000, 0);
`ifdef FETCH_RESP_ALIGN_CHECK_EN
    do_req(32'hBFC00006, 32'h00000000, 1'b1, 10'h000, 0);
`else
    do_req(32'hBFC00006, 32'hA5C30001, 1'b0, 10'h001, 0);
`endif
    do_req(32'hBFC00FFC, 32'hA5C303FF, 1'b0, 10'h3FF, 0);
    do_req(32'hBFC01000, 32'h00000000, 1'b1, 10'h000, 0);
    do_req(32'hBFBFFFFC, 32'h00000000, 1'b1, 10'h000, 0);
    do_req(32'hBFC00014, 32'hA5C30005, 1'b0, 10'h005, 5);
    do_req(32'h00000000, 32'h00000000, 1'b1, 10'h000, 5);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 32'hBFC00010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("wrst_req_ready", req_ready, 1);
    chk("wrst_rsp_valid", rsp_valid, 0);
    chk("wrst_rsp_err", rsp_err, 0);
    chk("wrst_rsp_data", rsp_data, 0);
    chk("wrst_mem_en", mem_en, 0);
    chk("wrst_mem_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    do_req(32'hBFC00008, 32'hA5C30002, 1'b0, 10'h002, 1);
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
